// File: rtl/skew_ctrl.sv
// skew_ctrl: sequencer for the shared-enable skew/deskew delay chains around
// the systolic array. It drives the common chain enable, the chain clear and
// the zero-injection select. A shadow valid/last pipe of depth D tracks which
// beats are in flight, so the array output is presented as a handshaked stream.
module skew_ctrl #(
  parameter int D  = 8,   // chain input to array output latency, >= 1
  parameter int BW = 16   // beat counter width
) (
  input  logic          c,
  input  logic          r,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          m_ready,
  output logic          m_valid,
  output logic          m_last,
  output logic          en,
  output logic          rnl,
  output logic          zero_in,
  output logic [BW-1:0] n_beats,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t         st, st_nx;
  logic [D-1:0]   vsr;      // shadow valid, one bit per chain stage
  logic [D-1:0]   lsr;      // shadow last, aligned with vsr
  logic           in_v;     // beat accepted this cycle
  logic           stall;    // output held by downstream
  logic           m_done;   // last beat of the packet handed off

  // Handshake and chain control are pure functions of state, shadows and inputs.
  always_comb begin
    stall   = vsr[D-1] & ~m_ready;
    s_ready = (st == RUN) & ~stall;
    in_v    = (st == RUN) & s_valid & s_ready;
    m_valid = vsr[D-1];
    m_last  = vsr[D-1] & lsr[D-1];
    m_done  = m_valid & m_ready & m_last;
    // Advance whenever something moves: a new beat, a beat in flight, or the
    // drain phase. FLUSH keeps the chains frozen while they are cleared.
    en      = ~stall & (in_v | (|vsr) | (st == DRAIN)) & (st != FLUSH);
    // Any advance without an accepted beat pushes a zero bubble.
    zero_in = ~in_v;
    rnl     = (st != FLUSH);
    busy    = (st != IDLE);
  end

  // Next-state logic. IDLE holds s_ready low, so the first beat lands in RUN.
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (s_valid)         st_nx = RUN;
      RUN:     if (in_v && s_last)  st_nx = DRAIN;
      DRAIN:   if (m_done)          st_nx = FLUSH;
      FLUSH:                        st_nx = IDLE;
      default:                      st_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge c or posedge r) begin
    if (r) st <= IDLE;
    else   st <= st_nx;
  end

  // Beat counter: counts accepted beats, saturates, cleared on the way out.
  always_ff @(posedge c or posedge r) begin
    if (r)                                n_beats <= '0;
    else if (st == FLUSH)                 n_beats <= '0;
    else if (in_v && (n_beats != {BW{1'b1}})) n_beats <= n_beats + 1'b1;
  end

  // Shadow pipes move in lockstep with the chains (same enable).
  generate
    if (D == 1) begin : g_d1
      // Single-stage shadow: the shift is just a load.
      always_ff @(posedge c or posedge r) begin
        if (r) begin
          vsr <= '0;
          lsr <= '0;
        end else if (st == FLUSH) begin
          vsr <= '0;
          lsr <= '0;
        end else if (en) begin
          vsr[0] <= in_v;
          lsr[0] <= in_v & s_last;
        end
      end
    end else begin : g_dn
      // Multi-stage shadow shift register, bit 0 is the chain input.
      always_ff @(posedge c or posedge r) begin
        if (r) begin
          vsr <= '0;
          lsr <= '0;
        end else if (st == FLUSH) begin
          vsr <= '0;
          lsr <= '0;
        end else if (en) begin
          vsr <= {vsr[D-2:0], in_v};
          lsr <= {lsr[D-2:0], in_v & s_last};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_skew_ctrl.sv
// Directed bench for skew_ctrl: D=8 instance for the packet flows and a
// D=1 / BW=2 instance for the degenerate shadow and counter saturation.
module tb_skew_ctrl;

  logic c = 1'b0;
  logic r;

  // D=8, BW=16 instance
  logic        sv, sl, mr;
  logic        s_ready, m_valid, m_last, en, rnl, zero_in, busy;
  logic [15:0] n_beats;

  // D=1, BW=2 instance
  logic        sv1, sl1, mr1;
  logic        s_ready1, m_valid1, m_last1, en1, rnl1, zero_in1, busy1;
  logic [1:0]  n_beats1;

  int n_cmp = 0;
  int n_err = 0;
  int hs;

  always #5 c = ~c;

  skew_ctrl #(.D(8), .BW(16)) u0 (
    .c(c), .r(r), .s_valid(sv), .s_last(sl), .s_ready(s_ready),
    .m_ready(mr), .m_valid(m_valid), .m_last(m_last), .en(en), .rnl(rnl),
    .zero_in(zero_in), .n_beats(n_beats), .busy(busy)
  );

  skew_ctrl #(.D(1), .BW(2)) u1 (
    .c(c), .r(r), .s_valid(sv1), .s_last(sl1), .s_ready(s_ready1),
    .m_ready(mr1), .m_valid(m_valid1), .m_last(m_last1), .en(en1), .rnl(rnl1),
    .zero_in(zero_in1), .n_beats(n_beats1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 4-beat packet, s_valid high for the beats, m_ready held high.
  task automatic pkt4(input string p);
    @(posedge c); #1;
    sv = 1; sl = 0; mr = 1;
    @(negedge c);
    chk({p, " idle s_ready"}, s_ready, 0);
    chk({p, " idle busy"}, busy, 0);
    for (int k = 0; k <= 13; k++) begin
      @(posedge c); #1;
      sv = (k < 4); sl = (k == 3);
      @(negedge c);
      chk($sformatf("%s k%0d s_ready", p, k), s_ready, (k < 4));
      chk($sformatf("%s k%0d m_valid", p, k), m_valid, (k >= 8 && k <= 11));
      chk($sformatf("%s k%0d m_last", p, k), m_last, (k == 11));
      chk($sformatf("%s k%0d rnl", p, k), rnl, (k != 12));
      chk($sformatf("%s k%0d busy", p, k), busy, (k <= 12));
      chk($sformatf("%s k%0d en", p, k), en, (k <= 11));
      chk($sformatf("%s k%0d zero_in", p, k), zero_in, !(k < 4));
      if (k == 11 || k == 12) chk($sformatf("%s k%0d n_beats", p, k), n_beats, 4);
      if (k == 13) chk($sformatf("%s k%0d n_beats clr", p, k), n_beats, 0);
    end
  endtask

  initial begin
    r = 1; sv = 0; sl = 0; mr = 1; sv1 = 0; sl1 = 0; mr1 = 1;
    repeat (2) @(posedge c);
    #1 r = 0;
    @(negedge c);
    chk("rst m_valid", m_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst n_beats", n_beats, 0);
    chk("rst en", en, 0);
    chk("rst rnl", rnl, 1);
    chk("rst s_ready", s_ready, 0);
    chk("rst zero_in", zero_in, 1);

    // 1: basic 4-beat packet
    pkt4("t1");

    // 2: same packet, output stalled for cycles 9..12
    @(posedge c); #1;
    sv = 1; sl = 0; mr = 1;
    hs = 0;
    for (int k = 0; k <= 17; k++) begin
      @(posedge c); #1;
      sv = (k < 4); sl = (k == 3); mr = !(k >= 9 && k <= 12);
      @(negedge c);
      chk($sformatf("t2 k%0d m_valid", k), m_valid, (k >= 8 && k <= 15));
      chk($sformatf("t2 k%0d m_last", k), m_last, (k == 15));
      chk($sformatf("t2 k%0d en", k), en, (k <= 8 || (k >= 13 && k <= 15)));
      chk($sformatf("t2 k%0d s_ready", k), s_ready, (k < 4));
      chk($sformatf("t2 k%0d rnl", k), rnl, (k != 16));
      chk($sformatf("t2 k%0d busy", k), busy, (k <= 16));
      if (m_valid && mr) hs++;
    end
    chk("t2 handshakes", hs, 4);

    // 3: input gaps, beats at 0, 2, 5(last)
    @(posedge c); #1;
    sv = 1; sl = 0; mr = 1;
    for (int k = 0; k <= 15; k++) begin
      @(posedge c); #1;
      sv = (k == 0 || k == 2 || k == 5); sl = (k == 5);
      @(negedge c);
      chk($sformatf("t3 k%0d zero_in", k), zero_in, !(k == 0 || k == 2 || k == 5));
      chk($sformatf("t3 k%0d m_valid", k), m_valid, (k == 8 || k == 10 || k == 13));
      chk($sformatf("t3 k%0d m_last", k), m_last, (k == 13));
      chk($sformatf("t3 k%0d en", k), en, (k <= 13));
      chk($sformatf("t3 k%0d n_beats", k), n_beats,
          (k == 15) ? 0 : ((k > 0) + (k > 2) + (k > 5)));
    end

    // 4: D=1 single-beat packet
    @(posedge c); #1;
    sv1 = 1; sl1 = 1; mr1 = 1;
    @(negedge c);
    chk("t4 idle s_ready", s_ready1, 0);
    for (int k = 0; k <= 3; k++) begin
      @(posedge c); #1;
      sv1 = (k == 0); sl1 = (k == 0);
      @(negedge c);
      chk($sformatf("t4 k%0d s_ready", k), s_ready1, (k == 0));
      chk($sformatf("t4 k%0d m_valid", k), m_valid1, (k == 1));
      chk($sformatf("t4 k%0d m_last", k), m_last1, (k == 1));
      chk($sformatf("t4 k%0d rnl", k), rnl1, (k != 2));
      chk($sformatf("t4 k%0d busy", k), busy1, (k <= 2));
    end

    // 8: BW=2 counter saturates at 3 over a 5-beat packet
    @(posedge c); #1;
    sv1 = 1; sl1 = 0; mr1 = 1;
    for (int k = 0; k <= 7; k++) begin
      @(posedge c); #1;
      sv1 = (k < 5); sl1 = (k == 4);
      @(negedge c);
      chk($sformatf("t8 k%0d n_beats", k), n_beats1,
          (k >= 7) ? 0 : ((k > 3) ? 3 : k));
      chk($sformatf("t8 k%0d m_valid", k), m_valid1, (k >= 1 && k <= 5));
      chk($sformatf("t8 k%0d m_last", k), m_last1, (k == 5));
    end

    // 7: stall while still accepting input (10-beat packet)
    @(posedge c); #1;
    sv = 1; sl = 0; mr = 1;
    hs = 0;
    for (int k = 0; k <= 21; k++) begin
      @(posedge c); #1;
      sv = (k <= 11); sl = (k == 11); mr = !(k == 8 || k == 9);
      @(negedge c);
      chk($sformatf("t7 k%0d s_ready", k), s_ready, (k < 8 || k == 10 || k == 11));
      chk($sformatf("t7 k%0d en", k), en, (k <= 19 && k != 8 && k != 9));
      chk($sformatf("t7 k%0d m_valid", k), m_valid, (k >= 8 && k <= 19));
      chk($sformatf("t7 k%0d m_last", k), m_last, (k == 19));
      chk($sformatf("t7 k%0d rnl", k), rnl, (k != 20));
      chk($sformatf("t7 k%0d busy", k), busy, (k <= 20));
      if (k == 9)  chk("t7 n_beats held", n_beats, 8);
      if (k == 12) chk("t7 n_beats end", n_beats, 10);
      if (m_valid && mr) hs++;
    end
    chk("t7 handshakes", hs, 10);

    // 5: async reset in DRAIN with 3 beats in flight
    @(posedge c); #1;
    sv = 1; sl = 0; mr = 1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge c); #1;
      sv = (k < 3); sl = (k == 2);
      @(negedge c);
    end
    chk("t5 pre busy", busy, 1);
    chk("t5 pre n_beats", n_beats, 3);
    chk("t5 pre en", en, 1);
    #1 r = 1;
    #1;
    chk("t5 rst m_valid", m_valid, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst n_beats", n_beats, 0);
    chk("t5 rst en", en, 0);
    chk("t5 rst rnl", rnl, 1);
    @(posedge c); #1;
    r = 0;
    pkt4("t5b");

    // 6: back-to-back packets with s_valid held high
    @(posedge c); #1;
    sv = 1; sl = 0; mr = 1;
    for (int k = 0; k <= 15; k++) begin
      @(posedge c); #1;
      sv = 1; sl = (k == 3);
      @(negedge c);
      chk($sformatf("t6 k%0d s_ready", k), s_ready, (k < 4 || k >= 14));
      chk($sformatf("t6 k%0d m_last", k), m_last, (k == 11));
      if (k == 13) chk("t6 idle busy", busy, 0);
      if (k == 14) chk("t6 n_beats restart", n_beats, 0);
      if (k == 15) chk("t6 n_beats first", n_beats, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/skew_ctrl.md
# skew_ctrl

Sequencer for the shared-enable skew/deskew delay chains that feed and drain the systolic array. It accepts an AXI-Stream-style packet of input vectors and drives the common enable (`en`), the synchronous local clear (`rnl`) and the zero-injection select (`zero_in`) of every delay chain. It tracks valid/last through a shadow pipeline of the same depth, so the array output appears as a handshaked stream with correct `m_last` and full backpressure. It sits between the input AXIS slave and the array datapath, one instance per array.

## Interface
- `D`, 8: cycles from chain input to array output for one beat (≥1).
- `BW`, 16: width of the beat counter.

- `c`  in  1  clock.
- `r`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  1  input beat valid.
- `s_last`  in  1  last beat of packet (qualified by `s_valid`).
- `s_ready`  out  1  input beat accepted when `s_valid & s_ready`.
- `m_ready`  in  1  downstream ready for array output.
- `m_valid`  out  1  array output beat valid.
- `m_last`  out  1  array output beat is last of packet.
- `en`  out  1  common enable to all delay chains and array registers.
- `rnl`  out  1  local clear to chains, active-low, synchronous.
- `zero_in`  out  1  selects zeros instead of `s_data` at chain inputs.
- `n_beats`  out  BW  input beats accepted in the current packet.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DRAIN, FLUSH. Reset: IDLE, shadow pipes 0, `n_beats` 0.
- Shadow pipes `vsr[D-1:0]` and `lsr[D-1:0]` shift only when `en`=1: `vsr <= {vsr[D-2:0], in_v}`, `lsr <= {lsr[D-2:0], in_v & s_last}`.
  - `in_v = (state==RUN) & s_valid & s_ready`.
- `m_valid = vsr[D-1]`; `m_last = vsr[D-1] & lsr[D-1]`.
- `stall = m_valid & ~m_ready`.
- `en = ~stall & (in_v | (|vsr) | state==DRAIN)`. With nothing in flight and no input, `en`=0.
- `s_ready = (state==RUN) & ~stall`.
- `zero_in = ~in_v`. Every advance without an accepted beat injects a zero bubble with valid=0.
- `rnl = 0` only in FLUSH; otherwise 1.
- IDLE → RUN when `s_valid`=1. `s_ready`=0 in IDLE, so the first beat is accepted no earlier than the next cycle.
- RUN → DRAIN on an accepted beat with `s_last`=1.
- DRAIN → FLUSH when `m_valid & m_ready & m_last`.
- FLUSH → IDLE unconditionally after 1 cycle.
  - In FLUSH, `vsr`/`lsr` clear to 0 and `n_beats` clears to 0.
  - `en`=0 in FLUSH.
- `n_beats` increments on each `in_v` and saturates at 2^BW-1. It holds through DRAIN and is readable until FLUSH.

## Timing
- Latency: a beat accepted in cycle t (no stalls) gives `m_valid`=1 in cycle t+D.
- Throughput: 1 beat/cycle while `m_ready`=1.
- Backpressure: `stall` freezes `en`, shadows, chains and `s_ready` in the same cycle. `m_valid`/`m_last` stay stable until accepted.
- Output consumed with no new input: `en`=1 and a bubble is inserted, so the output is never duplicated.
- `s_last` on the very first beat: RUN → DRAIN after one accepted beat. That beat appears at t+D with `m_last`=1.
- `s_valid` dropping mid-packet: the pipe keeps advancing with bubbles while `|vsr`, and the output gaps match the input gaps.
- `D`=1: shadow is a single bit and the shift degenerates to a load.
- Async `r` mid-packet: immediate return to IDLE, all outputs and state cleared. The chains are cleared by their own global reset.
- Packet turnaround: minimum 2 idle cycles between the output `m_last` handshake and the next `s_ready`=1 (FLUSH, then IDLE).

## Test plan
- D=8, 4-beat packet with s_valid held high and m_ready=1.
  - s_ready=1 for 4 cycles; m_valid high in cycles t0+8..t0+11; m_last in t0+11.
  - FLUSH pulses rnl=0 for 1 cycle; n_beats=4 before clear.
- Same packet, m_ready=0 for cycles t0+9..t0+12.
  - m_valid and m_last held stable; en=0 and s_ready=0 during the stall.
  - 4 output handshakes total; none duplicated or lost.
- Input gaps: beats at t0, t0+2, t0+5 (last).
  - m_valid at t0+8, t0+10, t0+13; zero_in=1 on the gap cycles.
- Single-beat packet (s_last on first beat) with D=1.
  - m_valid and m_last in the cycle after acceptance; state reaches IDLE 2 cycles later.
- Reset asserted in DRAIN with 3 beats in flight.
  - m_valid=0, busy=0, n_beats=0, en=0, rnl=1 immediately.
  - The next packet behaves as in the first test.
- Back-to-back packets.
  - Second packet's s_ready rises no earlier than 2 cycles after the first packet's m_last handshake.
  - n_beats restarts from 0.
